// File: rtl/host_snapshot_buffer_pkg.sv
// Shared constants, channel indices and FSM encoding for the ping-pong snapshot buffer.
package host_snapshot_buffer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_NUM_CH     = 3;

    localparam int CH_UX  = 0;
    localparam int CH_UY  = 1;
    localparam int CH_RHO = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } snap_state_t;

    // Extract one field word from a packed node record.
    function automatic logic [DEF_DATA_WIDTH-1:0] get_field(
        input logic [DEF_NUM_CH*DEF_DATA_WIDTH-1:0] data,
        input int                                   ch
    );
        return data[ch*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/host_snapshot_buffer_bank.sv
// One snapshot bank: NUM_CH-wide RAM with a single write port and a registered read port.
module snapshot_bank
    import host_snapshot_buffer_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_NUM_CH * DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WORD_WIDTH-1:0] o_rd_data
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rd_data;

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, holds its value between reads.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/host_snapshot_buffer.sv
// Ping-pong snapshot store between collider output and host link.
// Optional drop counter enabled by defining HOST_SNAP_DROP_CNT_EN.
module host_snapshot_buffer
    import host_snapshot_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_cap_active,
    input  logic                         i_cap_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_cap_data,
    input  logic                         i_host_lock,
    input  logic                         i_host_rd_en,
    input  logic [ADDR_WIDTH-1:0]        i_host_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_host_data,
    output logic                         o_host_valid,
    output logic                         o_frame_ready,
    output logic [ADDR_WIDTH:0]          o_frame_len,
    output logic                         o_overflow,
    output logic [7:0]                   o_drop_cnt
);

    localparam int                  WORD_WIDTH = NUM_CH * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L    = (ADDR_WIDTH + 1)'(DEPTH);

    snap_state_t           r_state;
    logic                  r_wr_bank;
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic                  r_ovf_pend;
    logic [ADDR_WIDTH:0]   r_frame_len;
    logic                  r_overflow;
    logic                  r_frame_ready;
    logic                  r_lock_d;
    logic                  r_host_valid;
    logic                  r_rd_sel;
    logic                  r_rd_oob;

    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_lock_rise;
    logic                  w_drop_evt;
    logic [WORD_WIDTH-1:0] w_rd_data0;
    logic [WORD_WIDTH-1:0] w_rd_data1;

    assign w_lock_rise = i_host_lock & ~r_lock_d;
    assign w_drop_evt  = (r_state == ST_COMMIT) & i_host_lock;

    // Write strobe/address: the first valid of a pass lands at address 0 straight from IDLE.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
        case (r_state)
            ST_IDLE: begin
                w_wr_addr = {ADDR_WIDTH{1'b0}};
                if (i_cap_active && i_cap_valid) begin
                    w_wr_en = 1'b1;
                end else begin
                    w_wr_en = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (i_cap_active && i_cap_valid && (r_wr_ptr < DEPTH_L)) begin
                    w_wr_en = 1'b1;
                end else begin
                    w_wr_en = 1'b0;
                end
            end
            default: begin
                w_wr_en = 1'b0;
            end
        endcase
    end

    // Capture/commit FSM and the committed-frame status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_wr_bank     <= 1'b0;
            r_wr_ptr      <= {(ADDR_WIDTH+1){1'b0}};
            r_ovf_pend    <= 1'b0;
            r_frame_len   <= {(ADDR_WIDTH+1){1'b0}};
            r_overflow    <= 1'b0;
            r_frame_ready <= 1'b0;
            r_lock_d      <= 1'b0;
        end else begin
            r_lock_d <= i_host_lock;
            if (w_lock_rise) begin
                r_frame_ready <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_cap_active) begin
                        r_wr_ptr   <= i_cap_valid ? (ADDR_WIDTH + 1)'(1) : {(ADDR_WIDTH+1){1'b0}};
                        r_ovf_pend <= 1'b0;
                        r_state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!i_cap_active) begin
                        r_state <= ST_COMMIT;
                    end else if (i_cap_valid) begin
                        if (r_wr_ptr < DEPTH_L) begin
                            r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH + 1)'(1);
                        end else begin
                            r_ovf_pend <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    // A held (or just-raised) lock discards the frame and keeps the banks as they are.
                    if (!i_host_lock) begin
                        r_wr_bank     <= ~r_wr_bank;
                        r_frame_len   <= r_wr_ptr;
                        r_overflow    <= r_ovf_pend;
                        r_frame_ready <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef HOST_SNAP_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of frames discarded under host lock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop_evt && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    logic w_drop_unused;
    assign w_drop_unused = w_drop_evt;
    assign o_drop_cnt    = 8'd0;
`endif

    // Read bookkeeping: remember which bank was read and whether the address was past the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_host_valid <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_rd_oob     <= 1'b1;
        end else begin
            r_host_valid <= i_host_rd_en;
            if (i_host_rd_en) begin
                r_rd_sel <= ~r_wr_bank;
                r_rd_oob <= ({1'b0, i_host_addr} >= r_frame_len);
            end
        end
    end

    snapshot_bank #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank0 (
        .clk       (clk),
        .i_wr_en   (w_wr_en & ~r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_cap_data),
        .i_rd_en   (i_host_rd_en & r_wr_bank),
        .i_rd_addr (i_host_addr),
        .o_rd_data (w_rd_data0)
    );

    snapshot_bank #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank1 (
        .clk       (clk),
        .i_wr_en   (w_wr_en & r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_cap_data),
        .i_rd_en   (i_host_rd_en & ~r_wr_bank),
        .i_rd_addr (i_host_addr),
        .o_rd_data (w_rd_data1)
    );

    assign o_host_data   = r_rd_oob ? {WORD_WIDTH{1'b0}} : (r_rd_sel ? w_rd_data1 : w_rd_data0);
    assign o_host_valid  = r_host_valid;
    assign o_frame_ready = r_frame_ready;
    assign o_frame_len   = r_frame_len;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_host_snapshot_buffer.sv
// Directed self-checking bench for host_snapshot_buffer (honours HOST_SNAP_DROP_CNT_EN).
module tb_host_snapshot_buffer;
    import host_snapshot_buffer_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int DP = DEF_DEPTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int NC = DEF_NUM_CH;

    logic              clk;
    logic              rst;
    logic              cap_active;
    logic              cap_valid;
    logic [NC*DW-1:0]  cap_data;
    logic              host_lock;
    logic              host_rd_en;
    logic [AW-1:0]     host_addr;
    logic [NC*DW-1:0]  host_data;
    logic              host_valid;
    logic              frame_ready;
    logic [AW:0]       frame_len;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    host_snapshot_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .i_cap_active  (cap_active),
        .i_cap_valid   (cap_valid),
        .i_cap_data    (cap_data),
        .i_host_lock   (host_lock),
        .i_host_rd_en  (host_rd_en),
        .i_host_addr   (host_addr),
        .o_host_data   (host_data),
        .o_host_valid  (host_valid),
        .o_frame_ready (frame_ready),
        .o_frame_len   (frame_len),
        .o_overflow    (overflow),
        .o_drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*DW-1:0] pack(input int ux, input int uy, input int rho);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        a = ux[DW-1:0];
        b = uy[DW-1:0];
        c = rho[DW-1:0];
        return {c, b, a};
    endfunction

    // Node i of a pass carries ux=i+off, uy=2*(i+off), rho=3*(i+off).
    task automatic run_pass(input int n, input int off, input bit lock_at_commit);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_active = 1'b1;
            cap_valid  = 1'b1;
            cap_data   = pack(i + off, 2 * (i + off), 3 * (i + off));
        end
        @(negedge clk);
        cap_active = 1'b0;
        cap_valid  = 1'b0;
        @(negedge clk);
        if (lock_at_commit) host_lock = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(input string tag, input int addr, input logic [NC*DW-1:0] exp);
        @(negedge clk);
        host_rd_en = 1'b1;
        host_addr  = addr[AW-1:0];
        @(negedge clk);
        host_rd_en = 1'b0;
        check_eq({tag, "_valid"}, 64'(host_valid), 64'd1);
        check_eq({tag, "_data"}, 64'(host_data), 64'(exp));
        @(negedge clk);
        check_eq({tag, "_vpulse"}, 64'(host_valid), 64'd0);
        check_eq({tag, "_hold"}, 64'(host_data), 64'(exp));
    endtask

    int exp_drop1;
    int exp_drop2;

    initial begin
`ifdef HOST_SNAP_DROP_CNT_EN
        exp_drop1 = 1;
        exp_drop2 = 2;
`else
        exp_drop1 = 0;
        exp_drop2 = 0;
`endif
        rst = 1'b0; cap_active = 1'b0; cap_valid = 1'b0; cap_data = '0;
        host_lock = 1'b0; host_rd_en = 1'b0; host_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check_eq("rst_data", 64'(host_data), 64'd0);
        check_eq("rst_valid", 64'(host_valid), 64'd0);
        check_eq("rst_ready", 64'(frame_ready), 64'd0);
        check_eq("rst_len", 64'(frame_len), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_drop", 64'(drop_cnt), 64'd0);

        // 1: five-node frame, then lock and read
        run_pass(5, 0, 1'b0);
        check_eq("t1_ready", 64'(frame_ready), 64'd1);
        check_eq("t1_len", 64'(frame_len), 64'd5);
        check_eq("t1_ovf", 64'(overflow), 64'd0);
        host_lock = 1'b1;
        @(negedge clk);
        check_eq("t1_ready_clr", 64'(frame_ready), 64'd0);
        do_read("t1_rd3", 3, pack(3, 6, 9));
        check_eq("t1_field_rho", 64'(get_field(host_data, CH_RHO)), 64'd9);

        // 3: lock held through a whole pass
        run_pass(5, 100, 1'b0);
        check_eq("t3_drop", 64'(drop_cnt), 64'(exp_drop1));
        check_eq("t3_ready", 64'(frame_ready), 64'd0);
        check_eq("t3_len", 64'(frame_len), 64'd5);
        do_read("t3_rd3", 3, pack(3, 6, 9));
        do_read("t3_rd4", 4, pack(4, 8, 12));

        // 4: lock rises exactly in the commit cycle
        host_lock = 1'b0;
        @(negedge clk);
        run_pass(3, 200, 1'b1);
        check_eq("t4_drop", 64'(drop_cnt), 64'(exp_drop2));
        check_eq("t4_ready", 64'(frame_ready), 64'd0);
        check_eq("t4_len", 64'(frame_len), 64'd5);
        do_read("t4_rd1", 1, pack(1, 2, 3));

        // 6: four-node frame, out-of-range read returns zero
        host_lock = 1'b0;
        @(negedge clk);
        run_pass(4, 10, 1'b0);
        check_eq("t6_len", 64'(frame_len), 64'd4);
        check_eq("t6_ready", 64'(frame_ready), 64'd1);
        do_read("t6_rd2", 2, pack(12, 24, 36));
        do_read("t6_rd7", 7, pack(0, 0, 0));
        do_read("t6_rd4", 4, pack(0, 0, 0));

        // 2: DEPTH+2 writes saturate and flag overflow
        run_pass(DP + 2, 0, 1'b0);
        check_eq("t2_len", 64'(frame_len), 64'(DP));
        check_eq("t2_ovf", 64'(overflow), 64'd1);
        do_read("t2_rdlast", DP - 1, pack(DP - 1, 2 * (DP - 1), 3 * (DP - 1)));
        do_read("t2_rd0", 0, pack(0, 0, 0));

        // 5: reset in the middle of a capture
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cap_active = 1'b1;
            cap_valid  = 1'b1;
            cap_data   = pack(70 + i, 71 + i, 72 + i);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cap_active = 1'b0;
        cap_valid  = 1'b0;
        check_eq("t5_data", 64'(host_data), 64'd0);
        check_eq("t5_valid", 64'(host_valid), 64'd0);
        check_eq("t5_ready", 64'(frame_ready), 64'd0);
        check_eq("t5_len", 64'(frame_len), 64'd0);
        check_eq("t5_ovf", 64'(overflow), 64'd0);
        check_eq("t5_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        run_pass(2, 50, 1'b0);
        check_eq("t5_len2", 64'(frame_len), 64'd2);
        check_eq("t5_ready2", 64'(frame_ready), 64'd1);
        check_eq("t5_ovf2", 64'(overflow), 64'd0);
        do_read("t5_rd1", 1, pack(51, 102, 153));
        do_read("t5_rd2", 2, pack(0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
